// File: rtl/div_seq_ctrl.sv
// Multi-cycle signed/unsigned W-bit divider sequencer, one non-restoring step per clock.
// Latency: done pulses W+1 edges after the accepting edge (first cycle after accept counts as 1, so done is in cycle W+2); divide-by-zero completes on the accepting edge.
// Backpressure: none; start is only honoured in IDLE, requests while busy or during done are dropped.
module div_seq_ctrl #(
   parameter int W  = 32,
   parameter int CW = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         is_signed,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic         div_by_zero,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder
);

   typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W:0]    a_q, a_d;          // partial remainder, one extra bit for the sign
   logic [W-1:0]  q_q, q_d;          // dividend magnitude shifting into quotient bits
   logic [W-1:0]  m_q, m_d;          // divisor magnitude
   logic          sign_q_q, sign_q_d;
   logic          sign_m_q, sign_m_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          dbz_q, dbz_d;
   logic [W-1:0]  quot_q, quot_d;
   logic [W-1:0]  rem_q, rem_d;

   logic [W-1:0]  mag_dd, mag_dv;
   logic [W:0]    a_sh, a_step;
   logic [W-1:0]  a_fix;

   // Operand magnitudes and the datapath for one non-restoring step and the final restore
   always_comb begin
      mag_dd = (is_signed && dividend[W-1]) ? (~dividend + W'(1)) : dividend;
      mag_dv = (is_signed && divisor[W-1])  ? (~divisor + W'(1))  : divisor;
      a_sh   = {a_q[W-1:0], q_q[W-1]};
      // Sign decision uses the pre-shift A; the W+1-bit wrap is harmless since the result lies in [-M, M)
      a_step = a_q[W] ? (a_sh + {1'b0, m_q}) : (a_sh - {1'b0, m_q});
      // Only the low W bits of the restored remainder matter: it is non-negative and below M
      a_fix  = a_q[W] ? (a_q[W-1:0] + m_q) : a_q[W-1:0];
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      q_d      = q_q;
      m_d      = m_q;
      sign_q_d = sign_q_q;
      sign_m_d = sign_m_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      dbz_d    = dbz_q;
      quot_d   = quot_q;
      rem_d    = rem_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               sign_q_d = is_signed & dividend[W-1];
               sign_m_d = is_signed & divisor[W-1];
               a_d      = '0;
               q_d      = mag_dd;
               m_d      = mag_dv;
               cnt_d    = '0;
               if (divisor == '0) begin
                  // Complete immediately: busy never rises, result is presented with done
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  dbz_d   = 1'b1;
                  quot_d  = '1;
                  rem_d   = dividend;
               end else begin
                  state_d = ITER;
                  busy_d  = 1'b1;
                  dbz_d   = 1'b0;
               end
            end
         end
         ITER: begin
            a_d   = a_step;
            q_d   = {q_q[W-2:0], ~a_step[W]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               state_d = FIXUP;
            end
         end
         FIXUP: begin
            quot_d  = (sign_q_q ^ sign_m_q) ? (~q_q + W'(1)) : q_q;
            rem_d   = sign_q_q ? (~a_fix + W'(1)) : a_fix;
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and result registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         q_q      <= '0;
         m_q      <= '0;
         sign_q_q <= 1'b0;
         sign_m_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
         quot_q   <= '0;
         rem_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         q_q      <= q_d;
         m_q      <= m_d;
         sign_q_q <= sign_q_d;
         sign_m_q <= sign_m_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dbz_q    <= dbz_d;
         quot_q   <= quot_d;
         rem_q    <= rem_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;

endmodule
